path_arbiter: RTL and testbench

PATH_ARBITER -- requirements
Module: path_arbiter

---
 rtl/path_arbiter.sv | 163 ++++++++++++++++
 tb/tb_path_arbiter.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/path_arbiter.sv
// Round-robin path allocator for four processors on a 2x2 mesh (P0 P1 / P2 P3).
// Each grant reserves one of two candidate paths plus the destination sink until its burst ends.
module path_arbiter (
    input  logic        clock,
    input  logic        reset,
    input  logic [3:0]  req,
    input  logic [7:0]  dest,
    input  logic [31:0] len,
    input  logic [27:0] path_free_bits,
    input  logic [3:0]  beat,
    output logic [3:0]  grant,
    output logic [3:0]  done,
    output logic [3:0]  active,
    output logic [11:0] path_sel,
    output logic [11:0] link_busy
);

    // Directed link bit within link_busy[7:0]: L01,L10,L23,L32,L02,L20,L13,L31 from bit 0 upward.
    function automatic logic [7:0] hop(input logic [1:0] a, input logic [1:0] b);
        logic [7:0] m;
        m = '0;
        case ({a, b})
            4'b0001: m[0] = 1'b1;
            4'b0100: m[1] = 1'b1;
            4'b1011: m[2] = 1'b1;
            4'b1110: m[3] = 1'b1;
            4'b0010: m[4] = 1'b1;
            4'b1000: m[5] = 1'b1;
            4'b0111: m[6] = 1'b1;
            4'b1101: m[7] = 1'b1;
            default: m = '0;
        endcase
        return m;
    endfunction

    // XOR 2'b01 steps horizontally, XOR 2'b10 steps vertically.
    function automatic logic [11:0] path_mask(input logic [1:0] s, input logic [1:0] d,
                                              input logic [2:0] idx);
        logic [7:0] links;
        links = '0;
        case (idx)
            3'd1, 3'd3: links = hop(s, d);
            3'd2:    links = hop(s, s ^ 2'b10) | hop(s ^ 2'b10, d ^ 2'b10) | hop(d ^ 2'b10, d);
            3'd4:    links = hop(s, s ^ 2'b01) | hop(s ^ 2'b01, d ^ 2'b01) | hop(d ^ 2'b01, d);
            3'd5:    links = hop(s, s ^ 2'b10) | hop(s ^ 2'b10, d);
            3'd6:    links = hop(s, s ^ 2'b01) | hop(s ^ 2'b01, d);
            default: links = '0;
        endcase
        return {4'b0001 << d, links};
    endfunction

    logic [7:0]  count      [4];
    logic [11:0] alloc_mask [4];
    logic [1:0]  rr;

    logic [2:0]  lo_idx     [4];
    logic [2:0]  hi_idx     [4];
    logic [2:0]  pick_idx   [4];
    logic [11:0] lo_mask    [4];
    logic [11:0] hi_mask    [4];
    logic [11:0] pick_mask  [4];
    logic [6:0]  free_i     [4];
    logic [3:0]  lo_ok;
    logic [3:0]  hi_ok;
    logic [3:0]  cand;

    // Per-processor candidate paths, eligibility, and preferred choice.
    always_comb begin
        cand  = '0;
        lo_ok = '0;
        hi_ok = '0;
        for (int i = 0; i < 4; i++) begin
            free_i[i] = path_free_bits[7*(3-i) +: 7];
            case (dest[2*i +: 2] ^ 2'(i))
                2'd0:    begin lo_idx[i] = 3'd0; hi_idx[i] = 3'd0; end
                2'd1:    begin lo_idx[i] = 3'd1; hi_idx[i] = 3'd2; end
                2'd2:    begin lo_idx[i] = 3'd3; hi_idx[i] = 3'd4; end
                default: begin lo_idx[i] = 3'd5; hi_idx[i] = 3'd6; end
            endcase
            lo_mask[i] = path_mask(2'(i), dest[2*i +: 2], lo_idx[i]);
            hi_mask[i] = path_mask(2'(i), dest[2*i +: 2], hi_idx[i]);
            lo_ok[i]   = free_i[i][lo_idx[i]] && ((lo_mask[i] & link_busy) == '0);
            hi_ok[i]   = free_i[i][hi_idx[i]] && ((hi_mask[i] & link_busy) == '0);
            if (lo_ok[i]) begin
                pick_idx[i]  = lo_idx[i];
                pick_mask[i] = lo_mask[i];
            end else begin
                pick_idx[i]  = hi_idx[i];
                pick_mask[i] = hi_mask[i];
            end
            cand[i] = req[i] && !active[i] && (lo_ok[i] || hi_ok[i]);
        end
    end

    logic       win_valid;
    logic [1:0] win;
    logic [1:0] probe;

    always_comb begin
        win_valid = 1'b0;
        win       = '0;
        probe     = '0;
        for (int k = 0; k < 4; k++) begin
            probe = rr + 2'(k);
            if (!win_valid && cand[probe]) begin
                win_valid = 1'b1;
                win       = probe;
            end
        end
    end

    logic [3:0]  fin;
    logic [3:0]  grant_vec;
    logic [11:0] release_mask;
    logic [11:0] grant_mask;

    // A burst finishes on the beat that takes its counter from 1 to 0.
    always_comb begin
        fin          = '0;
        grant_vec    = '0;
        release_mask = '0;
        grant_mask   = '0;
        for (int i = 0; i < 4; i++) begin
            fin[i] = active[i] && beat[i] && (count[i] == 8'd1);
            if (fin[i]) release_mask = release_mask | alloc_mask[i];
        end
        if (win_valid) begin
            grant_vec[win] = 1'b1;
            grant_mask     = pick_mask[win];
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            grant     <= '0;
            done      <= '0;
            active    <= '0;
            path_sel  <= '0;
            link_busy <= '0;
            rr        <= '0;
            for (int i = 0; i < 4; i++) begin
                count[i]      <= '0;
                alloc_mask[i] <= '0;
            end
        end else begin
            grant     <= grant_vec;
            done      <= fin;
            active    <= (active & ~fin) | grant_vec;
            link_busy <= (link_busy & ~release_mask) | grant_mask;
            if (win_valid) rr <= win + 2'd1;
            for (int i = 0; i < 4; i++) begin
                if (grant_vec[i]) begin
                    count[i]             <= (len[8*i +: 8] == 8'd0) ? 8'd1 : len[8*i +: 8];
                    path_sel[3*i +: 3]   <= pick_idx[i];
                    alloc_mask[i]        <= pick_mask[i];
                end else if (active[i] && beat[i]) begin
                    count[i] <= count[i] - 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_path_arbiter.sv
// Directed bench for path_arbiter: hand-computed grants, paths, link reservations and resets.
module tb_path_arbiter;

    logic        clock;
    logic        reset;
    logic [3:0]  req;
    logic [7:0]  dest;
    logic [31:0] len;
    logic [27:0] path_free_bits;
    logic [3:0]  beat;
    logic [3:0]  grant;
    logic [3:0]  done;
    logic [3:0]  active;
    logic [11:0] path_sel;
    logic [11:0] link_busy;

    int checks = 0;
    int errors = 0;

    localparam logic [27:0] ALL_FREE = 28'hFFFFFFF;

    path_arbiter dut (
        .clock          (clock),
        .reset          (reset),
        .req            (req),
        .dest           (dest),
        .len            (len),
        .path_free_bits (path_free_bits),
        .beat           (beat),
        .grant          (grant),
        .done           (done),
        .active         (active),
        .path_sel       (path_sel),
        .link_busy      (link_busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset          = 1'b0;
        req            = '0;
        dest           = '0;
        len            = '0;
        path_free_bits = ALL_FREE;
        beat           = '0;
        #2;
        check_output("rst_grant", 32'(grant), 32'h0);
        check_output("rst_done", 32'(done), 32'h0);
        check_output("rst_active", 32'(active), 32'h0);
        check_output("rst_path_sel", 32'(path_sel), 32'h0);
        check_output("rst_link_busy", 32'(link_busy), 32'h0);
        @(negedge clock);
        reset = 1'b1;

        // All four request their own node: one grant per cycle in order P0..P3.
        req  = 4'b1111;
        dest = 8'hE4;
        len  = 32'h01010101;
        tick();
        check_output("rr_g0", 32'(grant), 32'h1);
        check_output("rr_lb0", 32'(link_busy), 32'h100);
        tick();
        check_output("rr_g1", 32'(grant), 32'h2);
        check_output("rr_lb1", 32'(link_busy), 32'h300);
        tick();
        check_output("rr_g2", 32'(grant), 32'h4);
        tick();
        check_output("rr_g3", 32'(grant), 32'h8);
        check_output("rr_active", 32'(active), 32'hF);
        check_output("rr_lb3", 32'(link_busy), 32'hF00);
        check_output("rr_psel", 32'(path_sel), 32'h0);
        req  = '0;
        beat = 4'b1111;
        tick();
        check_output("rr_done", 32'(done), 32'hF);
        check_output("rr_active_clr", 32'(active), 32'h0);
        check_output("rr_lb_clr", 32'(link_busy), 32'h0);
        check_output("rr_grant_idle", 32'(grant), 32'h0);
        beat = '0;

        // Pointer wrapped to 0: P0 wins before P1.
        req = 4'b0011;
        tick();
        check_output("wrap_g0", 32'(grant), 32'h1);
        tick();
        check_output("wrap_g1", 32'(grant), 32'h2);
        req  = '0;
        beat = 4'b0011;
        tick();
        check_output("wrap_done", 32'(done), 32'h3);
        beat = '0;

        // Pointer at 2 with P1 and P3 requesting: P3 first.
        req = 4'b1010;
        tick();
        check_output("rr2_first", 32'(grant), 32'h8);
        tick();
        check_output("rr2_second", 32'(grant), 32'h2);
        req  = '0;
        beat = 4'b1010;
        tick();
        check_output("rr2_done", 32'(done), 32'hA);
        beat = '0;

        // P0 -> P1 direct, three beats.
        req  = 4'b0001;
        dest = 8'h01;
        len  = 32'h00000003;
        beat = 4'b0001;
        tick();
        check_output("b3_grant", 32'(grant), 32'h1);
        check_output("b3_psel", 32'(path_sel[2:0]), 32'h1);
        check_output("b3_lb", 32'(link_busy), 32'h201);
        req = '0;
        tick();
        check_output("b3_beat1", 32'(done), 32'h0);
        tick();
        check_output("b3_beat2", 32'(done), 32'h0);
        tick();
        check_output("b3_done", 32'(done), 32'h1);
        check_output("b3_active", 32'(active), 32'h0);
        check_output("b3_lb_clr", 32'(link_busy), 32'h0);
        beat = '0;
        tick();
        check_output("b3_done_pulse", 32'(done), 32'h0);

        // P2 -> P1 blocked by sink K1 until P0's burst releases it.
        req  = 4'b0001;
        dest = 8'h11;
        len  = 32'h00010002;
        tick();
        check_output("blk_g0", 32'(grant), 32'h1);
        req = 4'b0100;
        tick();
        check_output("blk_wait1", 32'(grant), 32'h0);
        tick();
        check_output("blk_wait2", 32'(grant), 32'h0);
        beat = 4'b0001;
        tick();
        check_output("blk_wait3", 32'(grant), 32'h0);
        tick();
        check_output("blk_done0", 32'(done), 32'h1);
        check_output("blk_nogrant", 32'(grant), 32'h0);
        beat = '0;
        tick();
        check_output("blk_g2", 32'(grant), 32'h4);
        check_output("blk_psel2", 32'(path_sel[8:6]), 32'h5);
        check_output("blk_lb2", 32'(link_busy), 32'h221);
        check_output("blk_done_off", 32'(done), 32'h0);
        req  = '0;
        beat = 4'b0100;
        tick();
        check_output("blk_done2", 32'(done), 32'h4);
        check_output("blk_lb_clr", 32'(link_busy), 32'h0);
        beat = '0;

        // P0 -> P3 with vertical-first path unavailable: horizontal-first instead.
        path_free_bits = 28'hBFFFFFF;
        req  = 4'b0001;
        dest = 8'h03;
        len  = 32'h00000001;
        tick();
        check_output("diag_grant", 32'(grant), 32'h1);
        check_output("diag_psel", 32'(path_sel[2:0]), 32'h6);
        check_output("diag_lb", 32'(link_busy), 32'h841);
        req            = '0;
        path_free_bits = ALL_FREE;
        beat           = 4'b0001;
        tick();
        check_output("diag_done", 32'(done), 32'h1);
        beat = '0;

        // P0 -> P1 with direct path unavailable: 3-hop via P2, P3.
        path_free_bits = 28'hFBFFFFF;
        req  = 4'b0001;
        dest = 8'h01;
        tick();
        check_output("hop3_psel", 32'(path_sel[2:0]), 32'h2);
        check_output("hop3_lb", 32'(link_busy), 32'h294);
        req            = '0;
        path_free_bits = ALL_FREE;
        beat           = 4'b0001;
        tick();
        check_output("hop3_done", 32'(done), 32'h1);
        beat = '0;

        // Zero length behaves as one beat.
        req  = 4'b0001;
        dest = 8'h00;
        len  = 32'h0;
        beat = 4'b0001;
        tick();
        check_output("len0_grant", 32'(grant), 32'h1);
        req = '0;
        tick();
        check_output("len0_done", 32'(done), 32'h1);

        // Long burst interrupted by reset: everything clears at once, no done.
        req  = 4'b0001;
        dest = 8'h01;
        len  = 32'd200;
        tick();
        check_output("long_grant", 32'(grant), 32'h1);
        req = '0;
        tick();
        tick();
        check_output("long_active", 32'(active), 32'h1);
        check_output("long_lb", 32'(link_busy), 32'h201);
        #3;
        reset = 1'b0;
        #1;
        check_output("arst_active", 32'(active), 32'h0);
        check_output("arst_lb", 32'(link_busy), 32'h0);
        check_output("arst_psel", 32'(path_sel), 32'h0);
        check_output("arst_done", 32'(done), 32'h0);
        tick();
        check_output("arst_hold_done", 32'(done), 32'h0);
        beat = '0;
        req  = 4'b0010;
        dest = 8'h04;
        @(negedge clock);
        reset = 1'b1;
        tick();
        check_output("post_rst_grant", 32'(grant), 32'h2);
        check_output("post_rst_lb", 32'(link_busy), 32'h200);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
